// File: rtl/sprite_move_grid.sv
// sprite_move_grid: grid-locked four-direction motion controller for maze sprites.
// Direction requests wait until the sprite can legally turn. A wall hit on the
// heading side stops the sprite and snaps it back onto the tile grid.
// Optional feature: define SPRITE_WRAP_EN for a horizontal wrap-around tunnel.
// Without it, X clamps to the visible area.
module sprite_move_grid #(
    parameter int INITIAL_X = 288,
    parameter int INITIAL_Y = 224,
    parameter int OBJECT_W  = 16,
    parameter int OBJECT_H  = 16,
    parameter int TILE      = 16,
    parameter int FRAC_BITS = 6,
    parameter int SPEED     = 64,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic [3:0]         dir_req,
    input  logic               freeze,
    input  logic               collision,
    input  logic [2:0]         HitEdgeCode,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY,
    output logic [1:0]         dir_out,
    output logic               moving
);
    localparam int unsigned POS_W = 32;
    localparam int unsigned PIX_W = 11;

    localparam logic signed [POS_W-1:0] TILE_FX   = POS_W'(TILE) <<< FRAC_BITS;
    localparam logic signed [POS_W-1:0] TILE_LSB  = TILE_FX - POS_W'(1);
    localparam logic signed [POS_W-1:0] SPEED_FX  = POS_W'(SPEED);
    localparam logic signed [POS_W-1:0] X_MAX_PIX = POS_W'(SCREEN_W - OBJECT_W);
    localparam logic signed [POS_W-1:0] Y_MAX_PIX = POS_W'(SCREEN_H - OBJECT_H);
    localparam logic signed [POS_W-1:0] X_MAX_FX  = X_MAX_PIX <<< FRAC_BITS;
    localparam logic signed [POS_W-1:0] Y_MAX_FX  = Y_MAX_PIX <<< FRAC_BITS;
`ifdef SPRITE_WRAP_EN
    localparam logic signed [POS_W-1:0] X_WRAP_LO = -POS_W'(OBJECT_W);
    localparam logic signed [POS_W-1:0] X_WRAP_HI = POS_W'(SCREEN_W);
    localparam logic signed [POS_W-1:0] WRAP_SPAN = POS_W'(SCREEN_W + OBJECT_W) <<< FRAC_BITS;
`endif

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    typedef enum logic [2:0] {MOVE, SOF_ST, TURN_ST, STEP_ST, LIMIT_ST} state_t;

    state_t                 state_q;
    logic signed [POS_W-1:0] x_q, y_q;
    logic [1:0]             dir_q;
    logic                   moving_q;
    logic                   pend_vld_q;
    logic [1:0]             pend_dir_q;
    logic [4:0]             hit_q;

    logic [1:0]             req_dir;
    logic                   aligned;
    logic                   turn_ok;
    logic signed [POS_W-1:0] x_pix, y_pix, x_lim, y_lim;
    logic                   lim_stop;

    // A side flag blocks the direction facing it; the corner flag never blocks.
    function automatic logic is_blocked(input logic [1:0] d, input logic [4:0] h);
        case (d)
            DIR_UP:    is_blocked = h[3];
            DIR_RIGHT: is_blocked = h[2];
            DIR_DOWN:  is_blocked = h[0];
            default:   is_blocked = h[1];
        endcase
    endfunction

    // Priority-encode the request and decide whether the pending turn may apply.
    always_comb begin
        req_dir = DIR_RIGHT;
        if (dir_req[3])      req_dir = DIR_UP;
        else if (dir_req[2]) req_dir = DIR_DOWN;
        else if (dir_req[1]) req_dir = DIR_LEFT;
        aligned = ((x_q & TILE_LSB) == '0) && ((y_q & TILE_LSB) == '0);
        turn_ok = pend_vld_q && !is_blocked(pend_dir_q, hit_q) &&
                  ((pend_dir_q == (dir_q ^ 2'd2)) || aligned || !moving_q);
    end

    // Screen limits: Y always clamps, X clamps or wraps.
    always_comb begin
        x_pix    = x_q >>> FRAC_BITS;
        y_pix    = y_q >>> FRAC_BITS;
        x_lim    = x_q;
        y_lim    = y_q;
        lim_stop = 1'b0;
        if (y_pix < 0) begin
            y_lim    = '0;
            lim_stop = 1'b1;
        end else if (y_pix > Y_MAX_PIX) begin
            y_lim    = Y_MAX_FX;
            lim_stop = 1'b1;
        end
`ifdef SPRITE_WRAP_EN
        if (x_pix < X_WRAP_LO)       x_lim = x_q + WRAP_SPAN;
        else if (x_pix >= X_WRAP_HI) x_lim = x_q - WRAP_SPAN;
`else
        if (x_pix < 0) begin
            x_lim    = '0;
            lim_stop = 1'b1;
        end else if (x_pix > X_MAX_PIX) begin
            x_lim    = X_MAX_FX;
            lim_stop = 1'b1;
        end
`endif
    end

    // Per-frame sequencer; published outputs only update on leaving LIMIT_ST.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= MOVE;
            x_q        <= POS_W'(INITIAL_X) <<< FRAC_BITS;
            y_q        <= POS_W'(INITIAL_Y) <<< FRAC_BITS;
            dir_q      <= DIR_LEFT;
            moving_q   <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_dir_q <= DIR_UP;
            hit_q      <= '0;
            topLeftX   <= PIX_W'(INITIAL_X);
            topLeftY   <= PIX_W'(INITIAL_Y);
            dir_out    <= DIR_LEFT;
            moving     <= 1'b0;
        end else begin
            case (state_q)
                MOVE: begin
                    if (dir_req != 4'd0) begin
                        pend_vld_q <= 1'b1;
                        pend_dir_q <= req_dir;
                    end
                    if (collision && (HitEdgeCode <= 3'd4)) hit_q[HitEdgeCode] <= 1'b1;
                    if (startOfFrame) state_q <= SOF_ST;
                end
                SOF_ST: begin
                    if (is_blocked(dir_q, hit_q)) begin
                        moving_q <= 1'b0;
                        case (dir_q)
                            DIR_UP:    y_q <= (y_q + TILE_LSB) & ~TILE_LSB;
                            DIR_RIGHT: x_q <= x_q & ~TILE_LSB;
                            DIR_DOWN:  y_q <= y_q & ~TILE_LSB;
                            default:   x_q <= (x_q + TILE_LSB) & ~TILE_LSB;
                        endcase
                    end
                    state_q <= TURN_ST;
                end
                TURN_ST: begin
                    if (turn_ok) begin
                        dir_q      <= pend_dir_q;
                        pend_vld_q <= 1'b0;
                        moving_q   <= 1'b1;
                    end
                    state_q <= STEP_ST;
                end
                STEP_ST: begin
                    if (moving_q && !freeze) begin
                        case (dir_q)
                            DIR_UP:    y_q <= y_q - SPEED_FX;
                            DIR_RIGHT: x_q <= x_q + SPEED_FX;
                            DIR_DOWN:  y_q <= y_q + SPEED_FX;
                            default:   x_q <= x_q - SPEED_FX;
                        endcase
                    end
                    hit_q   <= '0;
                    state_q <= LIMIT_ST;
                end
                LIMIT_ST: begin
                    x_q      <= x_lim;
                    y_q      <= y_lim;
                    if (lim_stop) moving_q <= 1'b0;
                    topLeftX <= PIX_W'(x_lim >>> FRAC_BITS);
                    topLeftY <= PIX_W'(y_lim >>> FRAC_BITS);
                    dir_out  <= dir_q;
                    moving   <= moving_q & ~lim_stop;
                    state_q  <= MOVE;
                end
                default: state_q <= MOVE;
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_move_grid.sv
// Testbench for sprite_move_grid: frame-level pixel model plus output scoreboard.
`timescale 1ns/1ps
module tb_sprite_move_grid;
    localparam int TILE = 16;
    localparam int SW   = 640;
    localparam int SH   = 480;
    localparam int OW   = 16;
    localparam int OH   = 16;

    logic              clk = 1'b0;
    logic              resetN;
    logic              startOfFrame;
    logic [3:0]        dir_req;
    logic              freeze;
    logic              collision;
    logic [2:0]        HitEdgeCode;
    logic signed [10:0] topLeftX, topLeftY;
    logic [1:0]        dir_out;
    logic              moving;

    always #5 clk = ~clk;

    sprite_move_grid dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .dir_req(dir_req),
        .freeze(freeze), .collision(collision), .HitEdgeCode(HitEdgeCode),
        .topLeftX(topLeftX), .topLeftY(topLeftY), .dir_out(dir_out), .moving(moving)
    );

    typedef struct {int x; int y; int d; int mv;} exp_t;
    exp_t exp_q[$];
    exp_t prev;
    int   checks = 0;
    int   passed = 0;
    bit   mon_en = 1'b0;

    // Reference model, in whole pixels (SPEED is exactly one pixel per frame).
    int m_x, m_y, m_d, m_mv, m_pv, m_pd;
    bit m_hit[5];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    endtask

    task automatic cmp_out(input string tag, input exp_t e);
        chk({tag, ".x"},      int'(topLeftX), e.x);
        chk({tag, ".y"},      int'(topLeftY), e.y);
        chk({tag, ".dir"},    int'(dir_out),  e.d);
        chk({tag, ".moving"}, int'(moving),   e.mv);
    endtask

    function automatic int floor_t(input int v);
        if (v >= 0) return (v / TILE) * TILE;
        return -(((-v) + TILE - 1) / TILE) * TILE;
    endfunction

    function automatic int ceil_t(input int v);
        return -floor_t(-v);
    endfunction

    // Wall side facing each heading: up->top(3) right->right(2) down->bottom(0) left->left(1)
    function automatic bit blocked(input int d);
        case (d)
            0: return m_hit[3];
            1: return m_hit[2];
            2: return m_hit[0];
            default: return m_hit[1];
        endcase
    endfunction

    function automatic int encode(input logic [3:0] r);
        if (r[3]) return 0;
        if (r[2]) return 2;
        if (r[1]) return 3;
        return 1;
    endfunction

    task automatic model_reset();
        m_x = 288; m_y = 224; m_d = 3; m_mv = 0; m_pv = 0; m_pd = 0;
        for (int i = 0; i < 5; i++) m_hit[i] = 1'b0;
    endtask

    task automatic model_frame(input bit frz);
        exp_t e;
        if (blocked(m_d)) begin
            m_mv = 0;
            case (m_d)
                0: m_y = ceil_t(m_y);
                1: m_x = floor_t(m_x);
                2: m_y = floor_t(m_y);
                default: m_x = ceil_t(m_x);
            endcase
        end
        if (m_pv != 0 && !blocked(m_pd) &&
            (m_pd == (m_d + 2) % 4 || (floor_t(m_x) == m_x && floor_t(m_y) == m_y) || m_mv == 0)) begin
            m_d = m_pd; m_pv = 0; m_mv = 1;
        end
        if (m_mv != 0 && !frz) begin
            case (m_d)
                0: m_y = m_y - 1;
                1: m_x = m_x + 1;
                2: m_y = m_y + 1;
                default: m_x = m_x - 1;
            endcase
        end
        for (int i = 0; i < 5; i++) m_hit[i] = 1'b0;
        if (m_y < 0) begin m_y = 0; m_mv = 0; end
        else if (m_y > SH - OH) begin m_y = SH - OH; m_mv = 0; end
`ifdef SPRITE_WRAP_EN
        if (m_x < -OW) m_x = m_x + SW + OW;
        else if (m_x >= SW) m_x = m_x - (SW + OW);
`else
        if (m_x < 0) begin m_x = 0; m_mv = 0; end
        else if (m_x > SW - OW) begin m_x = SW - OW; m_mv = 0; end
`endif
        e.x = m_x; e.y = m_y; e.d = m_d; e.mv = m_mv;
        exp_q.push_back(e);
    endtask

    // One frame: inputs held in MOVE, then a startOfFrame pulse, then idle.
    task automatic frame(input logic [3:0] req, input bit coll, input logic [2:0] code, input bit frz);
        @(negedge clk);
        dir_req = req; collision = coll; HitEdgeCode = code; freeze = frz;
        repeat (2) @(negedge clk);
        dir_req = 4'd0; collision = 1'b0;
        if (req != 4'd0) begin m_pv = 1; m_pd = encode(req); end
        if (coll && code < 3'd5) m_hit[code] = 1'b1;
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        model_frame(frz);
        repeat (10) @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) frame(4'd0, 1'b0, 3'd0, 1'b0);
    endtask

    // Monitor: outputs hold until the frame sequence completes, then match the model.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (startOfFrame && mon_en) begin
                #1 cmp_out("hold_sof", prev);
                repeat (3) @(negedge clk);
                cmp_out("hold_mid", prev);
                repeat (3) @(negedge clk);
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    cmp_out("frame", e);
                    prev = e;
                end
            end
        end
    end

    initial begin
        exp_t r;
        logic [3:0] rq;
        r.x = 288; r.y = 224; r.d = 3; r.mv = 0;
        resetN = 1'b0; startOfFrame = 1'b0; dir_req = 4'd0; freeze = 1'b0;
        collision = 1'b0; HitEdgeCode = 3'd0;
        model_reset();
        repeat (3) @(negedge clk);
        cmp_out("reset", r);
        resetN = 1'b1;
        prev = r;
        mon_en = 1'b1;

        idle(5);
        frame(4'b0001, 1'b0, 3'd0, 1'b0);
        idle(3);
        frame(4'b1000, 1'b0, 3'd0, 1'b0);
        idle(20);
        frame(4'b0010, 1'b0, 3'd0, 1'b0);
        idle(20);
        frame(4'd0, 1'b1, 3'd1, 1'b0);
        idle(2);
        frame(4'b0001, 1'b0, 3'd0, 1'b0);
        idle(3);
        for (int i = 0; i < 3; i++) frame(4'd0, 1'b0, 3'd0, 1'b1);
        idle(3);

        for (int i = 0; i < 300; i++) begin
            rq = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            frame(rq, ($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 9) == 0));
        end

        frame(4'b0010, 1'b0, 3'd0, 1'b0); idle(700);
        frame(4'b1000, 1'b0, 3'd0, 1'b0); idle(500);
        frame(4'b0001, 1'b0, 3'd0, 1'b0); idle(700);
        frame(4'b0100, 1'b0, 3'd0, 1'b0); idle(500);

        repeat (20) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        mon_en = 1'b0;

        // Reset in the middle of a frame sequence with an up request pending.
        dir_req = 4'b1000;
        repeat (2) @(negedge clk);
        dir_req = 4'd0;
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        resetN = 1'b0;
        #1 cmp_out("midreset", r);
        @(negedge clk);
        resetN = 1'b1;
        model_reset();
        prev = r;
        mon_en = 1'b1;
        idle(2);
        repeat (20) @(negedge clk);
        chk("queue_drained_end", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
